// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
//
// Control stage for the 8-bit datapath. Fetches 28-bit instructions from a
// synchronous-read ROM, latches them into IR, and drives the datapath control
// and address inputs for one execute cycle per instruction. An IN instruction
// waits on the external input handshake. HLTZ asks the datapath to test regA,
// then either halts or continues with the next instruction.
//
// Instruction fields: [27:24] class, [23:20] aluOp, [19:16] dest,
//                     [15:12] a, [11:8] b, [7:0] imm
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start               one-cycle pulse, leaves IDLE and begins at PC=0
//   instr_addr          ROM address (= PC)
//   instr_data          ROM data, valid one cycle after instr_addr
//   in_valid/in_data    external input byte offer
//   in_ready            sequencer accepts in_data this cycle
//   halt                registered halt flag from the datapath
//   writeEnable         register-file write strobe
//   writeSourceSelect   1 = write extInputData, 0 = write ALU result
//   muxASelect          1 = ALU A from extInputData
//   muxBSelect          1 = ALU B from extInputData
//   extInputData        immediate, or in_data while waiting for input
//   destAddress, aAddress, bAddress, aluOpCode   IR fields
//   haltCondition       request for the datapath halt-if-regA-zero check
//   busy, halted        status (busy = not IDLE and not HALTED)
//   illegal_op          sticky flag, an undefined class was executed
//   fsm_state           current FSM state, for observation
//
// Input handshake: a byte transfers in a cycle where in_ready and in_valid
// are both high at the rising clock edge. in_ready depends only on the state,
// never on in_valid, and in_valid is ignored whenever in_ready is low.
// -----------------------------------------------------------------------------
module program_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 28
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               halt,
  output logic               writeEnable,
  output logic               writeSourceSelect,
  output logic               muxASelect,
  output logic               muxBSelect,
  output logic [7:0]         extInputData,
  output logic [3:0]         destAddress,
  output logic [3:0]         aAddress,
  output logic [3:0]         bAddress,
  output logic [3:0]         aluOpCode,
  output logic               haltCondition,
  output logic               busy,
  output logic               halted,
  output logic               illegal_op,
  output logic [2:0]         fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT_IN = 3'd4,
    S_HCHK    = 3'd5,
    S_HALTED  = 3'd6
  } state_t;

  localparam logic [3:0] C_RR   = 4'h1;
  localparam logic [3:0] C_RI   = 4'h2;
  localparam logic [3:0] C_IR   = 4'h3;
  localparam logic [3:0] C_LDI  = 4'h4;
  localparam logic [3:0] C_IN   = 4'h5;
  localparam logic [3:0] C_HLTZ = 4'h6;
  localparam logic [3:0] C_JMP  = 4'h7;

  state_t             state;
  state_t             state_next;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               illegal_q;
  logic [3:0]         cls;
  logic               pc_step;
  logic               pc_jump;
  logic               pc_clear;
  logic               ir_load;
  logic               set_illegal;

  assign cls = ir[27:24];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and all control outputs, decoded from state and IR
  always_comb begin
    state_next        = state;
    pc_step           = 1'b0;
    pc_jump           = 1'b0;
    pc_clear          = 1'b0;
    ir_load           = 1'b0;
    set_illegal       = 1'b0;
    writeEnable       = 1'b0;
    writeSourceSelect = 1'b0;
    muxASelect        = 1'b0;
    muxBSelect        = 1'b0;
    haltCondition     = 1'b0;
    in_ready          = 1'b0;
    extInputData      = ir[7:0];

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          pc_clear   = 1'b1;
        end
      end

      S_FETCH:  state_next = S_DECODE;

      // ROM data for the address presented in FETCH is valid now
      S_DECODE: begin
        state_next = S_EXEC;
        ir_load    = 1'b1;
      end

      S_EXEC: begin
        state_next = S_FETCH;
        pc_step    = 1'b1;
        case (cls)
          C_RR:  writeEnable = 1'b1;
          C_RI: begin
            writeEnable = 1'b1;
            muxBSelect  = 1'b1;
          end
          C_IR: begin
            writeEnable = 1'b1;
            muxASelect  = 1'b1;
          end
          C_LDI: begin
            writeEnable       = 1'b1;
            writeSourceSelect = 1'b1;
          end
          // PC advances only once the byte has been accepted
          C_IN: begin
            state_next = S_WAIT_IN;
            pc_step    = 1'b0;
          end
          C_HLTZ: begin
            state_next    = S_HCHK;
            haltCondition = 1'b1;
          end
          C_JMP: begin
            pc_step = 1'b0;
            pc_jump = 1'b1;
          end
          // class 0 is NOP; classes 8-F behave as NOP but are flagged
          default: set_illegal = cls[3];
        endcase
      end

      S_WAIT_IN: begin
        in_ready     = 1'b1;
        extInputData = in_data;
        if (in_valid) begin
          writeEnable       = 1'b1;
          writeSourceSelect = 1'b1;
          pc_step           = 1'b1;
          state_next        = S_FETCH;
        end
      end

      // halt was registered by the datapath from the HLTZ execute cycle
      S_HCHK:   state_next = halt ? S_HALTED : S_FETCH;

      S_HALTED: state_next = S_HALTED;

      default:  state_next = S_IDLE;
    endcase
  end

  // Program counter, instruction register and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (pc_clear) begin
        pc <= '0;
      end else if (pc_jump) begin
        pc <= PC_W'(ir[7:0]);
      end else if (pc_step) begin
        pc <= pc + PC_W'(1);
      end
      if (ir_load) begin
        ir <= instr_data;
      end
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign instr_addr  = pc;
  assign destAddress = ir[19:16];
  assign aAddress    = ir[15:12];
  assign bAddress    = ir[11:8];
  assign aluOpCode   = ir[23:20];
  assign busy        = (state != S_IDLE) && (state != S_HALTED);
  assign halted      = (state == S_HALTED);
  assign illegal_op  = illegal_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_program_sequencer.sv
// -----------------------------------------------------------------------------
// tb_program_sequencer
//
// Runs directed programs and random programs. A program-level reference model
// walks the ROM instruction by instruction and predicts, by cycle number
// relative to the start pulse, every control event (write / select / halt
// request), the ROM address in every cycle, the number of in_ready and busy
// cycles, and the final halted / illegal_op status. The DUT is observed every
// cycle and compared against those predictions.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_program_sequencer;

  localparam int EW   = 53;
  localparam int MAXC = 1024;

  // ---------------- clock / DUT signals ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  instr_addr;
  logic [27:0] instr_data;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        halt;
  logic        writeEnable;
  logic        writeSourceSelect;
  logic        muxASelect;
  logic        muxBSelect;
  logic [7:0]  extInputData;
  logic [3:0]  destAddress;
  logic [3:0]  aAddress;
  logic [3:0]  bAddress;
  logic [3:0]  aluOpCode;
  logic        haltCondition;
  logic        busy;
  logic        halted;
  logic        illegal_op;
  logic [2:0]  fsm_state;

  always #5 clk = ~clk;

  program_sequencer #(.PC_W(8), .INSTR_W(28)) dut (
    .clk(clk), .rst(rst), .start(start),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .halt(halt),
    .writeEnable(writeEnable), .writeSourceSelect(writeSourceSelect),
    .muxASelect(muxASelect), .muxBSelect(muxBSelect),
    .extInputData(extInputData),
    .destAddress(destAddress), .aAddress(aAddress), .bAddress(bAddress),
    .aluOpCode(aluOpCode), .haltCondition(haltCondition),
    .busy(busy), .halted(halted), .illegal_op(illegal_op),
    .fsm_state(fsm_state)
  );

  // Synchronous-read instruction ROM
  logic [27:0] rom [256];
  always @(posedge clk) instr_data <= rom[instr_addr];

  // Per-run stimulus tables, consumed in execution order
  int          in_delay [128];
  logic [7:0]  in_bytes [128];
  logic        hlt_dec  [128];

  // Reference model results
  logic [EW-1:0] exp_q[$];
  logic [7:0]    exp_addr [MAXC];
  int            exp_rdy, exp_busy;
  logic          exp_halted, exp_illegal;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] ins(input int cls, input int op, input int d,
                                      input int a, input int b, input int imm);
    return {4'(cls), 4'(op), 4'(d), 4'(a), 4'(b), 8'(imm)};
  endfunction

  function automatic logic [EW-1:0] mk_evt(input int cyc, input logic we, input logic ws,
                                           input logic ma, input logic mb, input logic hc,
                                           input logic [7:0] ext, input logic [3:0] d,
                                           input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op, input logic [7:0] addr);
    return {16'(cyc), we, ws, ma, mb, hc, ext, d, a, b, op, addr};
  endfunction

  task automatic fill(input int lo, input int hi, input logic [7:0] v, input int lim);
    for (int k = lo; k <= hi; k++)
      if (k <= lim && k < MAXC) exp_addr[k] = v;
  endtask

  // Program-level model: each ordinary instruction takes 3 cycles with its
  // execute in the 3rd; IN waits from cycle 4 until the byte is offered; HLTZ
  // adds one check cycle. Cycle 0 is the cycle in which start is sampled.
  task automatic run_model(input int ncyc, input int rstc);
    int t, lim, di, hi, d, t_halt, t_ill, last;
    logic [7:0]  p;
    logic [27:0] ir;
    logic [3:0]  cls;
    bit stop;
    lim = (rstc > 0) ? rstc : ncyc;
    exp_q.delete();
    exp_rdy = 0; t = 0; p = 8'h00; di = 0; hi = 0; stop = 0; t_halt = -1; t_ill = -1;
    for (int k = 0; k < MAXC; k++) exp_addr[k] = 8'h00;
    while (!stop && t + 1 <= lim) begin
      ir  = rom[p];
      cls = ir[27:24];
      if (cls >= 4'd1 && cls <= 4'd4) begin
        fill(t + 1, t + 3, p, lim);
        if (t + 3 <= lim)
          exp_q.push_back(mk_evt(t + 3, 1'b1, cls == 4'd4, cls == 4'd3, cls == 4'd2, 1'b0,
                                 ir[7:0], ir[19:16], ir[15:12], ir[11:8], ir[23:20], p));
        p = p + 8'd1; t = t + 3;
      end else if (cls == 4'd5) begin
        d = in_delay[di];
        fill(t + 1, t + 4 + d, p, lim);
        if (t + 4 + d <= lim)
          exp_q.push_back(mk_evt(t + 4 + d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                 in_bytes[di], ir[19:16], ir[15:12], ir[11:8], ir[23:20], p));
        if (t + 4 <= lim) begin
          last = (t + 4 + d < lim) ? t + 4 + d : lim;
          exp_rdy += last - (t + 4) + 1;
        end
        di++; p = p + 8'd1; t = t + 4 + d;
      end else if (cls == 4'd6) begin
        fill(t + 1, t + 3, p, lim);
        if (t + 3 <= lim)
          exp_q.push_back(mk_evt(t + 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 ir[7:0], ir[19:16], ir[15:12], ir[11:8], ir[23:20], p));
        p = p + 8'd1;
        fill(t + 4, t + 4, p, lim);
        if (hlt_dec[hi]) begin
          stop = 1; t_halt = t + 5;
        end
        hi++; t = t + 4;
      end else if (cls == 4'd7) begin
        fill(t + 1, t + 3, p, lim);
        p = ir[7:0]; t = t + 3;
      end else begin
        fill(t + 1, t + 3, p, lim);
        if (cls >= 4'd8 && t_ill < 0) t_ill = t + 3;
        p = p + 8'd1; t = t + 3;
      end
    end
    fill(t + 1, ncyc, p, lim);
    if (rstc > 0) fill(rstc + 1, ncyc, 8'h00, ncyc);
    if (t_halt > 0) exp_busy = (t_halt - 1 < lim) ? t_halt - 1 : lim;
    else            exp_busy = lim;
    exp_halted  = (rstc == 0) && (t_halt > 0) && (t_halt <= ncyc);
    exp_illegal = (rstc == 0) && (t_ill >= 0) && (t_ill < ncyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"}, instr_addr, 8'h00);
    check({tag, "_strobes"}, {writeEnable, writeSourceSelect, muxASelect, muxBSelect,
                              haltCondition, in_ready}, 6'b0);
    check({tag, "_ext"}, extInputData, 8'h00);
    check({tag, "_fields"}, {destAddress, aAddress, bAddress, aluOpCode}, 16'h0);
    check({tag, "_status"}, {busy, halted, illegal_op}, 3'b000);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; halt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  // Pulses start, then drives inputs and observes the DUT for ncyc cycles.
  // rstc > 0 asserts rst during that cycle.
  task automatic run_dut(input string tag, input int ncyc, input int rstc);
    int wait_cnt, in_idx, h_idx, rdy_n, busy_n;
    logic prev_hc;
    logic [EW-1:0] obs, e;
    wait_cnt = 0; in_idx = 0; h_idx = 0; rdy_n = 0; busy_n = 0; prev_hc = 1'b0;
    @(posedge clk);
    #1 start = 1'b1; rst = 1'b0; in_valid = 1'b0; halt = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      // start noise is only legal while the program is running
      start = (rstc == 0) && ($urandom_range(0, 7) == 0);
      rst   = (c == rstc);
      halt  = prev_hc ? hlt_dec[h_idx] : 1'b0;
      if (prev_hc) h_idx++;
      if (in_ready) begin
        if (wait_cnt == in_delay[in_idx]) begin
          in_valid = 1'b1; in_data = in_bytes[in_idx]; in_idx++; wait_cnt = 0;
        end else begin
          in_valid = 1'b0; in_data = 8'($urandom); wait_cnt++;
        end
      end else begin
        in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
      end
      #1;
      prev_hc = haltCondition;
      rdy_n  += int'(in_ready);
      busy_n += int'(busy);
      check($sformatf("%s_addr@%0d", tag, c), instr_addr, exp_addr[c]);
      if (writeEnable | writeSourceSelect | muxASelect | muxBSelect | haltCondition) begin
        obs = mk_evt(c, writeEnable, writeSourceSelect, muxASelect, muxBSelect, haltCondition,
                     extInputData, destAddress, aAddress, bAddress, aluOpCode, instr_addr);
        if (exp_q.size() == 0) begin
          check($sformatf("%s_extra_evt@%0d", tag, c), obs, '0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s_evt@%0d", tag, c), obs, e);
        end
      end
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; halt = 1'b0;
    #1;
    check({tag, "_missing_evts"}, exp_q.size(), 0);
    check({tag, "_in_ready_cycles"}, rdy_n, exp_rdy);
    check({tag, "_busy_cycles"}, busy_n, exp_busy);
    check({tag, "_halted"}, halted, exp_halted);
    check({tag, "_illegal"}, illegal_op, exp_illegal);
    if (rstc > 0) check_reset_vals({tag, "_after_rst"});
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 256; k++) rom[k] = 28'h0;
    for (int k = 0; k < 128; k++) begin
      in_delay[k] = $urandom_range(0, 5);
      in_bytes[k] = 8'($urandom);
      hlt_dec[k]  = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic test(input string tag, input int ncyc, input int rstc, input bit reset_first);
    if (reset_first) do_reset();
    run_model(ncyc, rstc);
    run_dut(tag, ncyc, rstc);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; halt = 1'b0;
    clear_prog();
    do_reset();
    check_reset_vals("por");

    // LOADI / LOADI / ALU_RR then halt
    clear_prog();
    rom[0] = ins(4, 0, 1, 0, 0, 5);
    rom[1] = ins(4, 0, 2, 0, 0, 3);
    rom[2] = ins(1, 0, 15, 1, 2, 0);
    rom[3] = ins(6, 0, 0, 7, 0, 0); hlt_dec[0] = 1'b1;
    test("t1", 20, 0, 1);

    // IN with the byte offered 4 cycles after the wait begins
    clear_prog();
    rom[0] = ins(5, 0, 4, 0, 0, 0); in_delay[0] = 4; in_bytes[0] = 8'hA5;
    rom[1] = ins(6, 0, 0, 0, 0, 0); hlt_dec[0] = 1'b1;
    test("t2", 20, 0, 1);

    // HLTZ halting at once; HLTZ not halting, then halting
    clear_prog();
    rom[0] = ins(6, 0, 0, 7, 0, 0); hlt_dec[0] = 1'b1;
    test("t3a", 15, 0, 1);
    clear_prog();
    rom[0] = ins(6, 0, 0, 7, 0, 0); hlt_dec[0] = 1'b0;
    rom[1] = ins(2, 3, 5, 6, 0, 8'h42);
    rom[2] = ins(6, 0, 0, 5, 0, 0); hlt_dec[1] = 1'b1;
    test("t3b", 20, 0, 1);

    // JMP to the last address, NOP there, wrap to 0
    clear_prog();
    rom[0]   = ins(7, 0, 0, 0, 0, 8'hFF);
    rom[255] = ins(0, 0, 0, 0, 0, 0);
    test("t4", 15, 0, 1);

    // Illegal class then ALU_IR and halt
    clear_prog();
    rom[0] = ins(12, 5, 3, 2, 1, 8'h11);
    rom[1] = ins(3, 9, 6, 0, 4, 8'h7E);
    rom[2] = ins(6, 0, 0, 1, 0, 0); hlt_dec[0] = 1'b1;
    test("t5", 20, 0, 1);

    // Reset during WAIT_IN and during EXEC, then run again from PC=0 without reset
    clear_prog();
    rom[0] = ins(5, 0, 4, 0, 0, 0); in_delay[0] = 10;
    test("t6a", 12, 6, 1);
    clear_prog();
    rom[0] = ins(4, 0, 1, 0, 0, 5);
    rom[1] = ins(4, 0, 2, 0, 0, 3);
    test("t6b", 10, 3, 1);
    test("t6c", 12, 0, 0);

    // Random programs, some with a reset part-way through
    for (int n = 0; n < 24; n++) begin
      int cls, rc;
      clear_prog();
      for (int k = 0; k < 256; k++) begin
        cls = $urandom_range(0, 9);
        if (cls >= 8) cls = $urandom_range(8, 15);
        rom[k] = ins(cls, $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
      end
      rc = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 290) : 0;
      test($sformatf("rnd%0d", n), 300, rc, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", total, 0);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
